// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: shifts UART bytes into a 128-bit cipher block, checks the
// CRC on the externally deciphered block and hands it off with valid/ready.
module rx_frame_assembler #(
    parameter int NBYTES         = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_done,
    input  logic                  rx_ferr,
    output logic [8*NBYTES-1:0]   cipher_block,
    input  logic [8*NBYTES-1:0]   plain_in,
    input  logic                  crc_ok,
    output logic [8*NBYTES-1:0]   data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  crc_err,
    output logic                  rx_err,
    output logic                  timeout_err,
    output logic                  overrun,
    output logic [4:0]            byte_count,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [4:0] LAST = 5'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DELIVER} state_t;

    state_t               state_q, state_d;
    logic [8*NBYTES-1:0]  cipher_block_q, cipher_block_d;
    logic [8*NBYTES-1:0]  data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 crc_err_q, crc_err_d;
    logic                 rx_err_q, rx_err_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 overrun_q, overrun_d;
    logic [4:0]           byte_count_q, byte_count_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cipher_block_q <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            crc_err_q      <= 1'b0;
            rx_err_q       <= 1'b0;
            timeout_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
            byte_count_q   <= '0;
            tcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            cipher_block_q <= cipher_block_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            crc_err_q      <= crc_err_d;
            rx_err_q       <= rx_err_d;
            timeout_err_q  <= timeout_err_d;
            overrun_q      <= overrun_d;
            byte_count_q   <= byte_count_d;
            tcnt_q         <= tcnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cipher_block_d = cipher_block_q;
        data_out_d     = data_out_q;
        data_valid_d   = data_valid_q;
        crc_err_d      = 1'b0;
        rx_err_d       = 1'b0;
        timeout_err_d  = 1'b0;
        overrun_d      = overrun_q;
        byte_count_d   = byte_count_q;
        tcnt_d         = tcnt_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (rx_done && rx_ferr) begin
                    rx_err_d       = 1'b1;
                    byte_count_d   = '0;
                    cipher_block_d = '0;
                    tcnt_d         = '0;
                    state_d        = IDLE;
                end else if (rx_done) begin
                    cipher_block_d = {cipher_block_q[8*NBYTES-9:0], rx_byte};
                    byte_count_d   = byte_count_q + 5'd1;
                    tcnt_d         = '0;
                    state_d        = (byte_count_q == LAST) ? CHECK : COLLECT;
                end else if (state_q == COLLECT) begin
                    // expiry fires on the cycle the counter would reach TIMEOUT_CYCLES-1
                    if (tcnt_q == TLAST) begin
                        timeout_err_d  = 1'b1;
                        byte_count_d   = '0;
                        cipher_block_d = '0;
                        tcnt_d         = '0;
                        state_d        = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (crc_ok) begin
                    data_out_d   = plain_in;
                    data_valid_d = 1'b1;
                    state_d      = DELIVER;
                end else begin
                    crc_err_d    = 1'b1;
                    byte_count_d = '0;
                    state_d      = IDLE;
                end
            end
            DELIVER: begin
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    byte_count_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rx_done && (state_q == CHECK || state_q == DELIVER)) overrun_d = 1'b1;
    end

    assign cipher_block = cipher_block_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign crc_err      = crc_err_q;
    assign rx_err       = rx_err_q;
    assign timeout_err  = timeout_err_q;
    assign overrun      = overrun_q;
    assign byte_count   = byte_count_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb_rx_frame_assembler: scenario tasks with a queue of expected delivered blocks;
// a second instance with a short timeout covers the inter-byte timeout.
module tb_rx_frame_assembler;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   rx_byte = '0;
    logic         rx_done = 1'b0;
    logic         rx_ferr = 1'b0;
    logic [127:0] plain_in = '0;
    logic         crc_ok = 1'b0;
    logic         data_ready = 1'b0;
    logic [127:0] cipher_block, data_out;
    logic         data_valid, crc_err, rx_err, timeout_err, overrun, busy;
    logic [4:0]   byte_count;
    logic [127:0] t_cipher_block, t_data_out;
    logic         t_data_valid, t_crc_err, t_rx_err, t_timeout_err, t_overrun, t_busy;
    logic [4:0]   t_byte_count;

    logic [127:0] exp_q[$];
    int passed = 0;
    int total = 0;

    localparam logic [127:0] FRAME1 = 128'hDEADBEEFCAFEBABE1234567890ABCDEF;
    localparam logic [127:0] PLAIN1 = 128'h0123456789ABCDEF0011223344556677;

    always #5 clk = ~clk;

    rx_frame_assembler dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_done(rx_done), .rx_ferr(rx_ferr),
        .cipher_block(cipher_block), .plain_in(plain_in), .crc_ok(crc_ok),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .crc_err(crc_err), .rx_err(rx_err), .timeout_err(timeout_err), .overrun(overrun),
        .byte_count(byte_count), .busy(busy)
    );

    rx_frame_assembler #(.TIMEOUT_CYCLES(20)) dut_t (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_done(rx_done), .rx_ferr(rx_ferr),
        .cipher_block(t_cipher_block), .plain_in(plain_in), .crc_ok(crc_ok),
        .data_out(t_data_out), .data_valid(t_data_valid), .data_ready(data_ready),
        .crc_err(t_crc_err), .rx_err(t_rx_err), .timeout_err(t_timeout_err), .overrun(t_overrun),
        .byte_count(t_byte_count), .busy(t_busy)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr = 1'b0);
        rx_byte = b;
        rx_done = 1'b1;
        rx_ferr = ferr;
        tick();
        rx_done = 1'b0;
        rx_ferr = 1'b0;
    endtask

    task automatic send_bytes(input logic [127:0] blk, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send_byte(blk[127-8*i -: 8]);
            if (i != n - 1) tick(gap);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic wait_deliver(input string name);
        logic [127:0] exp;
        int n = 0;
        while (!data_valid && n < 10) begin tick(); n++; end
        total++;
        if (!data_valid) begin
            $display("FAIL %s_valid: data_valid=0 after %0d cycles, required 1", name, n);
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s_sb: delivery with empty expected queue, data_out=%h", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            if (data_out !== exp) $display("FAIL %s_data: data_out=%h required %h", name, data_out, exp);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++; if ({cipher_block, data_out} !== '0) $display("FAIL reset_blocks: cipher=%h data_out=%h required 0", cipher_block, data_out); else passed++;
        total++; if ({data_valid, crc_err, rx_err, timeout_err, overrun, byte_count, busy} !== '0)
            $display("FAIL reset_flags: flags=%b required 0", {data_valid, crc_err, rx_err, timeout_err, overrun, byte_count, busy}); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        crc_ok = 1'b1; plain_in = PLAIN1; data_ready = 1'b1;
        exp_q.push_back(PLAIN1);
        send_bytes(FRAME1, 16, 199);
        total++; if (cipher_block !== FRAME1) $display("FAIL nom_cipher: cipher=%h required %h", cipher_block, FRAME1); else passed++;
        total++; if (byte_count !== 5'd16 || busy !== 1'b1 || data_valid !== 1'b0)
            $display("FAIL nom_check_state: count=%0d busy=%b valid=%b required 16 1 0", byte_count, busy, data_valid); else passed++;
        tick();
        total++; if (data_valid !== 1'b1) $display("FAIL nom_latency: data_valid=%b required 1", data_valid); else passed++;
        total++; if (data_out !== exp_q[0]) $display("FAIL nom_data: data_out=%h required %h", data_out, exp_q[0]); else passed++;
        void'(exp_q.pop_front());
        tick();
        total++; if (data_valid !== 1'b0 || busy !== 1'b0 || byte_count !== 5'd0)
            $display("FAIL nom_done: valid=%b busy=%b count=%0d required 0 0 0", data_valid, busy, byte_count); else passed++;
        total++; if (cipher_block !== FRAME1) $display("FAIL nom_cipher_kept: cipher=%h required %h", cipher_block, FRAME1); else passed++;
    endtask

    task automatic test_crc_fail();
        logic [127:0] f2 = 128'h00112233445566778899AABBCCDDEEFF;
        crc_ok = 1'b0; plain_in = 128'hFFFF; data_ready = 1'b1;
        send_bytes(FRAME1, 16, 2);
        tick();
        total++; if (crc_err !== 1'b1 || data_valid !== 1'b0 || byte_count !== 5'd0 || busy !== 1'b0)
            $display("FAIL crc_pulse: crc_err=%b valid=%b count=%0d busy=%b required 1 0 0 0", crc_err, data_valid, byte_count, busy); else passed++;
        tick();
        total++; if (crc_err !== 1'b0 || data_valid !== 1'b0) $display("FAIL crc_one_cycle: crc_err=%b valid=%b required 0 0", crc_err, data_valid); else passed++;
        crc_ok = 1'b1; plain_in = ~PLAIN1;
        exp_q.push_back(~PLAIN1);
        send_bytes(f2, 16, 1);
        total++; if (cipher_block !== f2) $display("FAIL crc_next_cipher: cipher=%h required %h", cipher_block, f2); else passed++;
        wait_deliver("crc_next");
        tick(2);
    endtask

    task automatic test_backpressure();
        logic [127:0] p3 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        logic [127:0] exp;
        logic stable = 1'b1;
        crc_ok = 1'b1; plain_in = p3; data_ready = 1'b0;
        exp_q.push_back(p3);
        send_bytes(FRAME1, 16, 1);
        tick();
        exp = exp_q.pop_front();
        plain_in = '0;
        for (int i = 0; i < 50; i++) begin
            if (data_valid !== 1'b1 || data_out !== exp) stable = 1'b0;
            if (i == 20) send_byte(8'h55); else tick();
        end
        total++; if (!stable) $display("FAIL bp_stable: valid=%b data_out=%h required 1 %h", data_valid, data_out, exp); else passed++;
        total++; if (overrun !== 1'b1 || byte_count !== 5'd16 || cipher_block !== FRAME1)
            $display("FAIL bp_overrun: overrun=%b count=%0d cipher=%h required 1 16 %h", overrun, byte_count, cipher_block, FRAME1); else passed++;
        data_ready = 1'b1;
        tick();
        total++; if (data_valid !== 1'b0 || overrun !== 1'b1) $display("FAIL bp_release: valid=%b overrun=%b required 0 1", data_valid, overrun); else passed++;
        tick(3);
        total++; if (overrun !== 1'b1) $display("FAIL bp_sticky: overrun=%b required 1", overrun); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        send_bytes(FRAME1, 5, 2);
        tick(18);
        total++; if (t_timeout_err !== 1'b0 || t_byte_count !== 5'd5) $display("FAIL to_early: timeout_err=%b count=%0d required 0 5", t_timeout_err, t_byte_count); else passed++;
        tick();
        total++; if (t_timeout_err !== 1'b1 || t_byte_count !== 5'd0 || t_cipher_block !== '0 || t_busy !== 1'b0)
            $display("FAIL to_fire: timeout_err=%b count=%0d cipher=%h busy=%b required 1 0 0 0", t_timeout_err, t_byte_count, t_cipher_block, t_busy); else passed++;
        tick();
        total++; if (t_timeout_err !== 1'b0) $display("FAIL to_pulse: timeout_err=%b required 0", t_timeout_err); else passed++;
        send_bytes(FRAME1, 5, 2);
        tick(18);
        send_byte(8'h77);
        total++; if (t_timeout_err !== 1'b0 || t_byte_count !== 5'd6 || t_cipher_block[7:0] !== 8'h77)
            $display("FAIL to_coincide: timeout_err=%b count=%0d low=%h required 0 6 77", t_timeout_err, t_byte_count, t_cipher_block[7:0]); else passed++;
        do_reset();
    endtask

    task automatic test_framing();
        logic [127:0] p5 = 128'hFEDCBA98765432100123456789ABCDEF;
        crc_ok = 1'b1; data_ready = 1'b1;
        send_bytes(FRAME1, 8, 1);
        tick();
        send_byte(8'h99, 1'b1);
        total++; if (rx_err !== 1'b1 || busy !== 1'b0 || byte_count !== 5'd0 || cipher_block !== '0 || timeout_err !== 1'b0)
            $display("FAIL ferr_abort: rx_err=%b busy=%b count=%0d cipher=%h required 1 0 0 0", rx_err, busy, byte_count, cipher_block); else passed++;
        tick();
        total++; if (rx_err !== 1'b0) $display("FAIL ferr_pulse: rx_err=%b required 0", rx_err); else passed++;
        plain_in = p5;
        exp_q.push_back(p5);
        send_bytes(~FRAME1, 16, 1);
        total++; if (cipher_block !== ~FRAME1) $display("FAIL ferr_next_cipher: cipher=%h required %h", cipher_block, ~FRAME1); else passed++;
        wait_deliver("ferr_next");
        tick(2);
    endtask

    task automatic test_async_reset();
        send_bytes(FRAME1, 7, 1);
        total++; if (byte_count !== 5'd7) $display("FAIL ar_pre: count=%0d required 7", byte_count); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (byte_count !== 5'd0 || cipher_block !== '0 || busy !== 1'b0)
            $display("FAIL ar_collect: count=%0d cipher=%h busy=%b required 0 0 0", byte_count, cipher_block, busy); else passed++;
        reset = 1'b0;
        tick();
        crc_ok = 1'b1; plain_in = PLAIN1; data_ready = 1'b0;
        send_bytes(FRAME1, 16, 1);
        tick();
        send_byte(8'h01);
        total++; if (data_valid !== 1'b1 || overrun !== 1'b1) $display("FAIL ar_pre_deliver: valid=%b overrun=%b required 1 1", data_valid, overrun); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if ({cipher_block, data_out, data_valid, overrun, byte_count, busy} !== '0)
            $display("FAIL ar_deliver: valid=%b overrun=%b count=%0d busy=%b data_out=%h required all 0", data_valid, overrun, byte_count, busy, data_out); else passed++;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_crc_fail();
        test_backpressure();
        test_timeout();
        test_framing();
        test_async_reset();
        total++; if (exp_q.size() != 0) $display("FAIL sb_empty: %0d expected blocks undelivered, required 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rx_frame_assembler.md
Name: rx_frame_assembler

Overview:
Receive-side counterpart of the AES/CRC UART transmit chain.
- Collects 16 consecutive bytes from the UART receiver into a 128-bit cipher block, first byte received in the MSB.
- Presents the block to the external combinational decipher and CRC-check logic.
- Delivers the deciphered block with a valid/ready handshake, or flags a CRC, framing, timeout or overrun error.

Parameters:
NBYTES, 16, bytes per frame; cipher_block width is 8*NBYTES (only 16 is supported).
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_byte  input  8  received byte from UART_Rx
rx_done  input  1  one-cycle strobe; rx_byte is valid while it is high
rx_ferr  input  1  framing error (bad stop bit); qualified by rx_done
cipher_block  output  128  assembled ciphertext; drives the external decipher
plain_in  input  128  deciphered block returned combinationally by the external decipher
crc_ok  input  1  combinational CRC-check result on plain_in
data_out  output  128  delivered plaintext block
data_valid  output  1  data_out is valid
data_ready  input  1  downstream accepts data_out
crc_err  output  1  one-cycle pulse: CRC mismatch
rx_err  output  1  one-cycle pulse: frame aborted because of rx_ferr
timeout_err  output  1  one-cycle pulse: inter-byte timeout
overrun  output  1  sticky: a byte arrived while the block was not collecting
byte_count  output  5  bytes collected in the current frame, 0..16
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state IDLE.
  - All outputs 0: cipher_block, data_out, data_valid, crc_err, rx_err, timeout_err, overrun, byte_count, busy.
  - Timeout counter 0.
- States: IDLE, COLLECT, CHECK, DELIVER.
- Byte accept (IDLE or COLLECT, rx_done=1, rx_ferr=0):
  - cipher_block <= {cipher_block[119:0], rx_byte}.
  - byte_count <= byte_count+1.
  - Timeout counter <= 0.
  - From IDLE, state goes to COLLECT.
- Frame abort (IDLE or COLLECT, rx_done=1, rx_ferr=1):
  - Byte discarded.
  - rx_err pulses for 1 cycle.
  - byte_count <= 0, cipher_block <= 0, state <= IDLE.
- Timeout (COLLECT only):
  - The counter increments every cycle without rx_done.
  - When it reaches TIMEOUT_CYCLES-1: timeout_err pulses for 1 cycle, byte_count <= 0, cipher_block <= 0, counter <= 0, state <= IDLE.
  - No timeout in IDLE.
  - If rx_done coincides with expiry, the byte wins: it is accepted or aborted per rx_ferr, and no timeout_err is raised.
- The 16th accepted byte moves the state to CHECK. byte_count reads 16 in CHECK and in DELIVER.
- CHECK (exactly 1 cycle): cipher_block is stable and crc_ok/plain_in are sampled at the edge.
  - crc_ok=1: data_out <= plain_in, data_valid <= 1, state <= DELIVER.
  - crc_ok=0: crc_err pulses for 1 cycle, data_out unchanged, byte_count <= 0, state <= IDLE.
- DELIVER:
  - data_valid and data_out are held stable until data_ready=1 at a rising edge.
  - At that edge: data_valid <= 0, byte_count <= 0, state <= IDLE.
  - No timeout applies in DELIVER.
- Latency: 16th rx_done sampled at edge k -> CHECK after edge k -> data_valid high after edge k+1.
- rx_done in CHECK or DELIVER: the byte is dropped, overrun <= 1 (sticky until reset), and the frame in progress is unaffected.
- cipher_block keeps its last value after a successful delivery or a CRC error. It is cleared only by reset, rx_ferr abort or timeout.
- data_ready while data_valid=0 is ignored.
- Error pulses are mutually exclusive per cycle.
- busy is a combinational decode of state != IDLE.
- Counters are unsigned. The timeout counter is sized $clog2(TIMEOUT_CYCLES) bits and never wraps, because it is cleared on expiry.

Test Plan:
1. Nominal frame: bytes DE AD BE EF CA FE BA BE 12 34 56 78 90 AB CD EF sent 200 cycles apart, crc_ok=1, plain_in=128'h0123456789ABCDEF0011223344556677, data_ready=1 -> cipher_block=128'hDEADBEEFCAFEBABE1234567890ABCDEF; data_valid high for exactly 1 cycle, 2 cycles after the 16th strobe; data_out=plain_in; busy low again afterwards.
2. CRC fail: same frame with crc_ok=0 -> crc_err 1-cycle pulse, data_valid never rises, byte_count returns to 0, and the next frame is received normally.
3. Backpressure plus overrun: data_ready held 0 for 50 cycles with a byte 0x55 injected during DELIVER -> data_valid and data_out stable for 50 cycles, overrun=1 and stays 1 after delivery until reset.
4. Timeout: TIMEOUT_CYCLES=20, send 5 bytes then stop -> timeout_err pulses 19 cycles after the 5th strobe, byte_count=0, cipher_block=0. Also rx_done arriving exactly at expiry -> accepted, no timeout_err.
5. Framing error: rx_ferr=1 on the 9th byte -> rx_err pulse, state IDLE, byte_count=0; the next 16 good bytes produce a correct frame.
6. Asynchronous reset asserted mid-COLLECT (byte_count=7) and mid-DELIVER -> all outputs 0 immediately, without waiting for a clock edge.
